// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED sequencer: state encoding and display codes.
package led_pkg;

  localparam int LED_W_DFLT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [7:0] PAT0 = 8'h10;
  localparam logic [7:0] PAT1 = 8'h92;
  localparam logic [7:0] PAT2 = 8'h53;
  localparam logic [7:0] PAT3 = 8'hEE;
  localparam logic [7:0] PAT4 = 8'h77;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle between the surrounding top level and the LED sequencer.
interface led_seq_ctrl_if #(
  parameter int LED_W = 8
);
  logic             start;
  logic             abort;
  logic             loop_en;
  logic [LED_W-1:0] led;
  logic             busy;
  logic             done;
  logic [3:0]       step_idx;

  modport master (output start, abort, loop_en, input led, busy, done, step_idx);
  modport slave  (input start, abort, loop_en, output led, busy, done, step_idx);
endinterface

// File: rtl/led_pattern_rom.sv
// 16-entry display-code table; entries past the defined patterns read as blank.
module led_pattern_rom
  import led_pkg::*;
#(
  parameter int LED_W = LED_W_DFLT
) (
  input  logic [3:0]       idx,
  output logic [LED_W-1:0] code
);
  always_comb begin
    code = '0;
    case (idx)
      4'd0:    code = LED_W'(PAT0);
      4'd1:    code = LED_W'(PAT1);
      4'd2:    code = LED_W'(PAT2);
      4'd3:    code = LED_W'(PAT3);
      4'd4:    code = LED_W'(PAT4);
      default: code = '0;
    endcase
  end
endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: steps through the pattern table, holding each code for DWELL cycles.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int DWELL     = 25000000,
  parameter int NUM_STEPS = 5,
  parameter int LED_W     = LED_W_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  led_seq_ctrl_if.slave bus
);
  localparam int             CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
  localparam logic [3:0]     IDX_LAST = 4'(NUM_STEPS - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [LED_W-1:0] code, led_q, led_nxt;
  logic             busy_q, busy_nxt, done_q, done_nxt;

  // ROM is addressed by the next index so the code lands in led alongside step_idx
  led_pattern_rom #(.LED_W(LED_W)) u_rom (.idx(idx_nxt), .code(code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      led_q  <= led_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          idx_nxt = '0;
          if (bus.start) state_nxt = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (idx != IDX_LAST) idx_nxt = idx + 4'd1;
            else begin
              idx_nxt = '0;
              if (!bus.loop_en) state_nxt = ST_FINISH;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy_nxt = (state_nxt == ST_SHOW);
    done_nxt = (state_nxt == ST_FINISH);
    led_nxt  = busy_nxt ? code : '0;
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = idx;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench: main instance DWELL=4/NUM_STEPS=5, edge instance DWELL=1/NUM_STEPS=1.
module tb_led_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] pat [5] = '{8'h10, 8'h92, 8'h53, 8'hEE, 8'h77};

  always #5 clk = ~clk;

  led_seq_ctrl_if #(.LED_W(8)) m_if ();
  led_seq_ctrl_if #(.LED_W(8)) e_if ();

  led_seq_ctrl #(.DWELL(4), .NUM_STEPS(5), .LED_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(m_if));
  led_seq_ctrl #(.DWELL(1), .NUM_STEPS(1), .LED_W(8)) dut_e (.clk(clk), .rst_n(rst_n), .bus(e_if));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic [7:0] l, input logic b, input logic d,
                       input logic [3:0] i);
    chk({tag, ".led"},  32'(m_if.led), 32'(l));
    chk({tag, ".busy"}, 32'(m_if.busy), 32'(b));
    chk({tag, ".done"}, 32'(m_if.done), 32'(d));
    chk({tag, ".idx"},  32'(m_if.step_idx), 32'(i));
  endtask

  task automatic chk_e(input string tag, input logic [7:0] l, input logic b, input logic d);
    chk({tag, ".led"},  32'(e_if.led), 32'(l));
    chk({tag, ".busy"}, 32'(e_if.busy), 32'(b));
    chk({tag, ".done"}, 32'(e_if.done), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0;
    m_if.start = 0; m_if.abort = 0; m_if.loop_en = 0;
    e_if.start = 0; e_if.abort = 0; e_if.loop_en = 0;
    repeat (2) @(negedge clk);
    chk_m("reset", 8'h00, 0, 0, 0);
    chk_e("reset_e", 8'h00, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic run: cycles 1-20 showing, done at 21
    m_if.start = 1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      m_if.start = 0;
      if (c <= 20)      chk_m("basic", pat[(c-1)/4], 1, 0, 4'((c-1)/4));
      else if (c == 21) chk_m("basic_done", 8'h00, 0, 1, 0);
      else              chk_m("basic_idle", 8'h00, 0, 0, 0);
    end

    // loop twice, loop_en dropped mid second pass
    m_if.loop_en = 1; m_if.start = 1;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      m_if.start = 0;
      if (c == 25) m_if.loop_en = 0;
      if (c <= 40)      chk_m("loop", pat[((c-1)%20)/4], 1, 0, 4'(((c-1)%20)/4));
      else if (c == 41) chk_m("loop_done", 8'h00, 0, 1, 0);
      else              chk_m("loop_idle", 8'h00, 0, 0, 0);
    end

    // abort at cycle 7, restart at cycle 10
    m_if.start = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      m_if.start = (c == 10);
      m_if.abort = (c == 7);
      if (c <= 7)       chk_m("abort_run", pat[(c-1)/4], 1, 0, 4'((c-1)/4));
      else if (c <= 10) chk_m("abort_idle", 8'h00, 0, 0, 0);
      else              chk_m("abort_restart", pat[0], 1, 0, 0);
    end
    m_if.start = 0; m_if.abort = 1;
    @(negedge clk);
    m_if.abort = 0;
    @(negedge clk);
    chk_m("abort_clean", 8'h00, 0, 0, 0);

    // start+abort together in IDLE
    m_if.start = 1; m_if.abort = 1;
    @(negedge clk);
    m_if.start = 0; m_if.abort = 0;
    chk_m("start_abort", 8'h00, 0, 0, 0);
    @(negedge clk);
    chk_m("start_abort2", 8'h00, 0, 0, 0);

    // start held high through the whole run
    m_if.start = 1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c <= 20)      chk_m("held", pat[(c-1)/4], 1, 0, 4'((c-1)/4));
      else if (c == 21) chk_m("held_done", 8'h00, 0, 1, 0);
      else if (c == 22) chk_m("held_idle", 8'h00, 0, 0, 0);
      else              chk_m("held_rerun", pat[0], 1, 0, 0);
    end
    m_if.start = 0; m_if.abort = 1;
    @(negedge clk);
    m_if.abort = 0;
    @(negedge clk);
    chk_m("held_clean", 8'h00, 0, 0, 0);

    // async reset between edges during step index 2
    m_if.start = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      m_if.start = 0;
      chk_m("pre_rst", pat[(c-1)/4], 1, 0, 4'((c-1)/4));
    end
    #2 rst_n = 1'b0;
    #1 chk_m("async_rst", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_m("post_rst_idle", 8'h00, 0, 0, 0);
    end
    m_if.start = 1;
    @(negedge clk);
    m_if.start = 0;
    chk_m("post_rst_run", pat[0], 1, 0, 0);
    m_if.abort = 1;
    @(negedge clk);
    m_if.abort = 0;

    // DWELL=1, NUM_STEPS=1 instance
    e_if.start = 1;
    @(negedge clk);
    e_if.start = 0;
    chk_e("edge_show", 8'h10, 1, 0);
    @(negedge clk);
    chk_e("edge_done", 8'h00, 0, 1);
    @(negedge clk);
    chk_e("edge_idle", 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
